// File: rtl/riscv_run_ctrl_pkg.sv
// riscv_ctrl_pkg: shared width defaults and run-controller state encoding
package riscv_ctrl_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W = 32;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ARM   = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } run_state_e;
endpackage

// File: rtl/riscv_run_ctrl_if.sv
// riscv_run_ctrl_if: valid/ready instruction word stream into the run controller
interface riscv_run_ctrl_if import riscv_ctrl_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
);
  logic s_valid;
  logic s_ready;
  logic [DATA_W-1:0] s_data;
  modport master (output s_valid, output s_data, input s_ready);
  modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/riscv_instr_loader.sv
// riscv_instr_loader: word index, registered imem write stage and last-beat detect
module riscv_instr_loader import riscv_ctrl_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              beat,
  input  logic              kill,
  input  logic [ADDR_W:0]   num,
  input  logic [DATA_W-1:0] data,
  output logic              last,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);
  logic [ADDR_W-1:0] k;
  logic take;
  assign take = beat && !kill;
  assign last = beat && ({1'b0, k} == num - (ADDR_W+1)'(1));
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k <= '0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
    end else begin
      wr <= take;
      if (clear) k <= '0;
      else if (take) k <= k + ADDR_W'(1);
      if (take) begin
        addr <= k;
        wdata <= data;
      end
    end
  end
endmodule

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: loads a program into imem, clears dmem and runs the core until halt or budget
module riscv_run_ctrl import riscv_ctrl_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [ADDR_W:0]    i_num_instr,
  input  logic [CNT_W-1:0]   i_run_cycles,
  input  logic               i_halt,
  riscv_run_ctrl_if.slave    s,
  output logic               o_instruction_write,
  output logic [ADDR_W-1:0]  o_instruction_addr,
  output logic [DATA_W-1:0]  o_instruction_data,
  output logic               o_core_reset_n,
  output logic               o_mem_reset_n,
  output logic               o_running,
  output logic               o_done,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_cycle_count
);
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_LOAD = ST_LOAD;
  localparam logic [2:0] S_ARM = ST_ARM;
  localparam logic [2:0] S_RUN = ST_RUN;
  localparam logic [2:0] S_DONE = ST_DONE;
  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(1) << ADDR_W;
  logic [2:0] state, nxt;
  logic [ADDR_W:0] num;
  logic [CNT_W-1:0] budget, cnt_inc;
  logic abort_ok, start_ok, beat, last, halt_exit, budget_exit;
  assign abort_ok = i_abort && state != S_IDLE;
  assign start_ok = i_start && !abort_ok && (state == S_IDLE || state == S_DONE)
                    && i_num_instr != '0 && i_num_instr <= MAX_N;
  assign beat = s.s_valid && state == S_LOAD;
  // an unlimited run parks the counter at all-ones instead of wrapping
  assign cnt_inc = &o_cycle_count ? o_cycle_count : o_cycle_count + CNT_W'(1);
  assign halt_exit = state == S_RUN && i_halt;
  assign budget_exit = state == S_RUN && budget != '0 && cnt_inc == budget;
  assign nxt = abort_ok                     ? S_IDLE  :
               start_ok                     ? S_CLEAR :
               state == S_CLEAR             ? S_LOAD  :
               state == S_LOAD && last      ? S_ARM   :
               state == S_ARM               ? S_RUN   :
               halt_exit || budget_exit     ? S_DONE  : state;
  assign s.s_ready = state == S_LOAD;
  assign o_running = state == S_RUN;
  assign o_done = state == S_DONE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      num <= '0;
      budget <= '0;
      o_cycle_count <= '0;
      o_timeout <= 1'b0;
      o_core_reset_n <= 1'b0;
      o_mem_reset_n <= 1'b1;
    end else begin
      state <= nxt;
      o_core_reset_n <= nxt == S_RUN;
      o_mem_reset_n <= nxt != S_CLEAR;
      if (start_ok) begin
        num <= i_num_instr;
        budget <= i_run_cycles;
        o_cycle_count <= '0;
        o_timeout <= 1'b0;
      end
      if (state == S_RUN && !abort_ok) begin
        o_cycle_count <= cnt_inc;
        o_timeout <= budget_exit && !i_halt;
      end
    end
  end
  riscv_instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_loader (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_ok),
    .beat    (beat),
    .kill    (abort_ok),
    .num     (num),
    .data    (s.s_data),
    .last    (last),
    .wr      (o_instruction_write),
    .addr    (o_instruction_addr),
    .wdata   (o_instruction_data)
  );
endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb_riscv_run_ctrl: table-driven and randomized runs checked against a run-outcome model
module tb_riscv_run_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, i_start = 1'b0, i_abort = 1'b0, i_halt = 1'b0;
  logic [8:0] i_num_instr = '0;
  logic [31:0] i_run_cycles = '0;
  logic o_instruction_write, o_core_reset_n, o_mem_reset_n, o_running, o_done, o_timeout;
  logic [7:0] o_instruction_addr;
  logic [31:0] o_instruction_data, o_cycle_count;
  riscv_run_ctrl_if #(.DATA_W(32)) s();
  riscv_run_ctrl dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_num_instr(i_num_instr), .i_run_cycles(i_run_cycles), .i_halt(i_halt), .s(s),
    .o_instruction_write(o_instruction_write), .o_instruction_addr(o_instruction_addr),
    .o_instruction_data(o_instruction_data), .o_core_reset_n(o_core_reset_n),
    .o_mem_reset_n(o_mem_reset_n), .o_running(o_running), .o_done(o_done),
    .o_timeout(o_timeout), .o_cycle_count(o_cycle_count)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int wr_cnt = 0, mrst_cnt = 0, bad_wr = 0, inv_err = 0, cur_n = 0;
  logic [31:0] imem [256];
  logic [31:0] words [256];
  typedef struct { int n; logic [31:0] r; int h; int gap; logic [31:0] ec; logic et; } vec_t;
  vec_t tbl [7];
  always @(negedge clk) begin
    if (o_instruction_write === 1'b1) begin
      imem[o_instruction_addr] <= o_instruction_data;
      wr_cnt <= wr_cnt + 1;
      if (int'(o_instruction_addr) >= cur_n) bad_wr <= bad_wr + 1;
    end
    if (o_mem_reset_n === 1'b0) mrst_cnt <= mrst_cnt + 1;
    if (o_core_reset_n !== o_running) inv_err <= inv_err + 1;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask
  function automatic void model(input int h, input logic [31:0] r, output logic [31:0] c, output logic t);
    if (h > 0 && (r == 0 || h <= int'(r))) begin c = 32'(h); t = 1'b0; end
    else begin c = r; t = 1'b1; end
  endfunction
  task automatic run_prog(input string nm, input int n, input logic [31:0] r, input int h,
                          input int gap, input int start_at, input logic [31:0] ec, input logic et);
    int idx, rc, lat, wr0, mr0, bw0, mism;
    logic fin;
    idx = 0; rc = 0; lat = -1; fin = 1'b0; mism = 0;
    cur_n = n; wr0 = wr_cnt; mr0 = mrst_cnt; bw0 = bad_wr;
    @(negedge clk);
    i_num_instr = 9'(n); i_run_cycles = r; i_start = 1'b1;
    for (int cyc = 1; cyc <= 4 * n + 200 + int'(r) + h; cyc++) begin
      @(negedge clk);
      i_start = 1'b0; i_halt = 1'b0;
      if (o_done) begin fin = 1'b1; break; end
      if (o_running) begin
        rc++;
        if (lat < 0) lat = cyc;
        i_halt = (rc == h);
        if (rc == start_at) begin i_start = 1'b1; i_num_instr = 9'd2; end
      end
      s.s_valid = 1'b0;
      if (idx < n) begin
        s.s_valid = ($urandom_range(99) >= gap);
        s.s_data = words[idx];
        if (s.s_valid && s.s_ready) idx++;
      end
    end
    s.s_valid = 1'b0;
    for (int i = 0; i < n; i++) if (imem[i] !== words[i]) mism++;
    chk({nm, ":finished"}, fin, 1);
    chk({nm, ":cycle_count"}, o_cycle_count, ec);
    chk({nm, ":timeout"}, o_timeout, et);
    chk({nm, ":run_cycles"}, rc, ec);
    chk({nm, ":writes"}, wr_cnt - wr0, n);
    chk({nm, ":mem_clear_cycles"}, mrst_cnt - mr0, 1);
    chk({nm, ":out_of_range_writes"}, bad_wr - bw0, 0);
    chk({nm, ":imem_mismatches"}, mism, 0);
    if (gap == 0) chk({nm, ":start_to_run"}, lat, n + 3);
  endtask
  initial begin
    logic [31:0] ec;
    logic et;
    int n, h, cnt0;
    logic [31:0] r;
    tbl[0] = '{4, 0, 6, 0, 6, 1'b0};
    tbl[1] = '{1, 10, 0, 0, 10, 1'b1};
    tbl[2] = '{3, 10, 10, 0, 10, 1'b0};
    tbl[3] = '{2, 5, 3, 30, 3, 1'b0};
    tbl[4] = '{5, 1, 0, 0, 1, 1'b1};
    tbl[5] = '{1, 0, 1, 0, 1, 1'b0};
    tbl[6] = '{256, 2, 0, 40, 2, 1'b1};
    s.s_valid = 1'b0; s.s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst:core_reset_n", o_core_reset_n, 0);
    chk("rst:mem_reset_n", o_mem_reset_n, 1);
    chk("rst:write", o_instruction_write, 0);
    chk("rst:addr", o_instruction_addr, 0);
    chk("rst:data", o_instruction_data, 0);
    chk("rst:ready_running_done", {s.s_ready, o_running, o_done, o_timeout}, 0);
    chk("rst:cycle_count", o_cycle_count, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < tbl[i].n; j++) words[j] = $urandom;
      if (i == 0) begin
        words[0] = 32'h00500093; words[1] = 32'h00A00113;
        words[2] = 32'h002081B3; words[3] = 32'h00000013;
      end
      run_prog($sformatf("vec%0d", i), tbl[i].n, tbl[i].r, tbl[i].h, tbl[i].gap, 0, tbl[i].ec, tbl[i].et);
    end
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 12);
      r = 32'($urandom_range(0, 15));
      h = (r == 0) ? $urandom_range(1, 20) : $urandom_range(0, 20);
      for (int j = 0; j < n; j++) words[j] = $urandom;
      model(h, r, ec, et);
      run_prog($sformatf("rand%0d", i), n, r, h, $urandom_range(0, 50), 0, ec, et);
    end
    // abort after two beats, with a third word offered in the abort cycle
    cur_n = 4; cnt0 = wr_cnt;
    @(negedge clk); i_num_instr = 9'd4; i_run_cycles = 0; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    @(negedge clk); s.s_valid = 1'b1; s.s_data = 32'h11;
    @(negedge clk); s.s_data = 32'h22;
    chk("abort:in_load", s.s_ready, 1);
    @(negedge clk); s.s_data = 32'h33; i_abort = 1'b1;
    @(negedge clk); i_abort = 1'b0; s.s_valid = 1'b0;
    chk("abort:ready", s.s_ready, 0);
    chk("abort:write", o_instruction_write, 0);
    chk("abort:core_reset_n", o_core_reset_n, 0);
    repeat (3) @(negedge clk);
    chk("abort:writes", wr_cnt - cnt0, 2);
    chk("abort:word1", imem[1], 32'h22);
    for (int j = 0; j < 2; j++) words[j] = $urandom;
    run_prog("restart", 2, 0, 3, 0, 0, 3, 1'b0);
    words[0] = $urandom;
    run_prog("start_in_run", 1, 0, 8, 0, 3, 8, 1'b0);
    @(negedge clk); i_abort = 1'b1; i_start = 1'b1; i_num_instr = 9'd3;
    @(negedge clk); i_abort = 1'b0; i_start = 1'b0;
    chk("abort_done:done", o_done, 0);
    chk("abort_done:mem_reset_n", o_mem_reset_n, 1);
    chk("abort_done:cycle_count", o_cycle_count, 8);
    i_start = 1'b1; i_num_instr = 9'd0;
    @(negedge clk); i_num_instr = 9'd257;
    @(negedge clk); i_start = 1'b0;
    @(negedge clk);
    chk("bad_start:mem_reset_n", o_mem_reset_n, 1);
    chk("bad_start:state", {s.s_ready, o_running, o_done}, 0);
    chk("bad_start:cycle_count", o_cycle_count, 8);
    // synchronous reset pulse during an unlimited run
    cur_n = 1; words[0] = $urandom;
    @(negedge clk); i_num_instr = 9'd1; i_run_cycles = 0; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0; s.s_valid = 1'b1; s.s_data = words[0];
    for (int c = 0; c < 20 && !o_running; c++) @(negedge clk);
    s.s_valid = 1'b0;
    chk("rst_run:reached_run", o_running, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("rst_run:core_reset_n", o_core_reset_n, 0);
    chk("rst_run:mem_reset_n", o_mem_reset_n, 1);
    chk("rst_run:write_addr_data", {o_instruction_write, o_instruction_addr, o_instruction_data}, 0);
    chk("rst_run:flags", {s.s_ready, o_running, o_done, o_timeout}, 0);
    chk("rst_run:cycle_count", o_cycle_count, 0);
    @(negedge clk);
    chk("core_reset_n_tracks_running", inv_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
